// File: rtl/alu_op_issuer.sv
// Issue stage for the ALU: buffers host requests in an in-order FIFO and drives
// the ALU ports one op at a time, pacing by command latency.
//
// state | meaning
// IDLE  | ALU quiet; pops the FIFO head when non-empty and not held
// ISSUE | CE=1 with operands and INP_VALID presented for one cycle
// WAIT  | CE=1, INP_VALID=00; down-counter runs to op_done at terminal count
module alu_op_issuer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_mode,
    input  logic [CMD_WIDTH-1:0] req_cmd,
    input  logic [WIDTH-1:0]     req_opa,
    input  logic [WIDTH-1:0]     req_opb,
    input  logic                 req_cin,
    input  logic [1:0]           req_inp_valid,
    input  logic                 hold,
    output logic [1:0]           INP_VALID,
    output logic                 MODE,
    output logic [CMD_WIDTH-1:0] CMD,
    output logic                 CE,
    output logic [WIDTH-1:0]     OPA,
    output logic [WIDTH-1:0]     OPB,
    output logic                 CIN,
    output logic                 op_done,
    output logic                 drop_pulse,
    output logic [15:0]          issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + CMD_WIDTH + 2 * WIDTH + 1 + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         wcnt;
    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;
    logic               pop;
    logic [EW-1:0]      wr_entry;
    logic [EW-1:0]      head;
    logic               head_mode;
    logic [CMD_WIDTH-1:0] head_cmd;
    logic [WIDTH-1:0]   head_opa;
    logic [WIDTH-1:0]   head_opb;
    logic               head_cin;
    logic [1:0]         head_iv;
    logic [1:0]         lat;

    assign req_ready = (count < (AW + 1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0) && !hold;
    assign wr_entry  = {req_mode, req_cmd, req_opa, req_opb, req_cin, req_inp_valid};
    assign head      = mem[rd_ptr];
    assign {head_mode, head_cmd, head_opa, head_opb, head_cin, head_iv} = head;

    // Multiply commands need an extra result cycle.
    assign lat = (MODE && (CMD == CMD_WIDTH'(9) || CMD == CMD_WIDTH'(10))) ? 2'd2 : 2'd1;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            wcnt       <= '0;
            INP_VALID  <= '0;
            MODE       <= 1'b0;
            CMD        <= '0;
            CE         <= 1'b0;
            OPA        <= '0;
            OPB        <= '0;
            CIN        <= 1'b0;
            op_done    <= 1'b0;
            drop_pulse <= 1'b0;
            issued_cnt <= '0;
        end else begin
            op_done    <= 1'b0;
            drop_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    CE        <= 1'b0;
                    INP_VALID <= 2'b00;
                    if (pop) begin
                        if (head_iv == 2'b00) begin
                            drop_pulse <= 1'b1;
                        end else begin
                            INP_VALID  <= head_iv;
                            MODE       <= head_mode;
                            CMD        <= head_cmd;
                            OPA        <= head_opa;
                            OPB        <= head_opb;
                            CIN        <= head_cin;
                            CE         <= 1'b1;
                            issued_cnt <= issued_cnt + 16'd1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    INP_VALID <= 2'b00;
                    wcnt      <= lat;
                    op_done   <= (lat == 2'd1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wcnt == 2'd1) begin
                        CE    <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wcnt    <= wcnt - 2'd1;
                        op_done <= (wcnt == 2'd2);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
